// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared types and constants for the set-associative data cache:
//            controller state encoding, line metadata record, memory commands.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WB     = 3'd2,
        S_FETCH  = 3'd3,
        S_FILL   = 3'd4,
        S_RESP   = 3'd5
    } cache_state_e;

    // Widest tag the metadata record can carry; narrower tags sit in the LSBs
    localparam int TAG_MAX = 32;

    // Per-line metadata record
    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } cache_line_t;

    // Memory request command encoding
    localparam logic MEM_RD = 1'b1;
    localparam logic MEM_WR = 1'b0;

endpackage
`default_nettype wire

// File: rtl/cache_way_sel.sv
`default_nettype none
// ============================================================================
// Module   : cache_way_sel
// Purpose  : Combinational tag compare across all ways of a set, one-hot hit
//            vector with encoded hit way, and victim choice (lowest invalid
//            way first, otherwise the set's round-robin pointer).
// Revision : 1.0 - initial release
// ============================================================================
module cache_way_sel #(
    parameter int WAYS    = 4,
    parameter int TAG_LEN = 17,
    parameter int WAY_W   = 2
) (
    input  wire logic [TAG_LEN-1:0]      i_tag,
    input  wire logic [WAYS*TAG_LEN-1:0] i_way_tags,
    input  wire logic [WAYS-1:0]         i_valid,
    input  wire logic [WAY_W-1:0]        i_rr_ptr,
    output logic      [WAYS-1:0]         o_hit_onehot,
    output logic                         o_hit,
    output logic      [WAY_W-1:0]        o_hit_way,
    output logic      [WAY_W-1:0]        o_victim_way
);

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_cmp
            assign o_hit_onehot[g] = i_valid[g] && (i_way_tags[g*TAG_LEN +: TAG_LEN] == i_tag);
        end
    endgenerate

    assign o_hit = |o_hit_onehot;

    // Encode the one-hot hit vector (only one bit may be set)
    always_comb begin
        o_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (o_hit_onehot[w]) o_hit_way = o_hit_way | WAY_W'(w);
        end
    end

    // Victim: scan downwards so the lowest invalid way wins, else round-robin
    always_comb begin
        o_victim_way = i_rr_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!i_valid[w]) o_victim_way = WAY_W'(w);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : cache_assoc
// Purpose  : N-way set-associative write-back / write-allocate data cache
//            between the core LSU and the main-memory request FIFO. Blocking,
//            one request at a time, round-robin replacement, posted
//            write-backs. Optional statistics counters under CACHE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cache_assoc
    import cache_pkg::*;
#(
    parameter  int DATA_LEN       = 32,
    parameter  int ADDR_LEN       = 27,
    parameter  int WORDS_PER_LINE = 4,
    parameter  int SETS           = 256,
    parameter  int WAYS           = 4,
    localparam int LINE_SIZE      = DATA_LEN * WORDS_PER_LINE
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 req_valid,
    output logic                      req_ready,
    input  wire logic                 req_we,
    input  wire logic [ADDR_LEN-1:0]  req_addr,
    input  wire logic [DATA_LEN-1:0]  req_wdata,
    output logic                      rsp_valid,
    output logic      [DATA_LEN-1:0]  rsp_rdata,
    output logic                      mem_req_en,
    input  wire logic                 mem_req_rdy,
    output logic                      mem_req_cmd,
    output logic      [ADDR_LEN-1:0]  mem_req_addr,
    output logic      [LINE_SIZE-1:0] mem_req_data,
    input  wire logic                 mem_rsp_en,
    input  wire logic [LINE_SIZE-1:0] mem_rsp_data
`ifdef CACHE_STATS_EN
    ,
    output logic      [31:0]          stat_hits,
    output logic      [31:0]          stat_misses,
    output logic      [31:0]          stat_wbs
`endif
);

    localparam int OFFSET_LEN = $clog2(WORDS_PER_LINE);
    localparam int INDEX_LEN  = $clog2(SETS);
    localparam int TAG_LEN    = ADDR_LEN - INDEX_LEN - OFFSET_LEN;
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

    // Tag/data arrays (RAM, never reset) and per-set metadata flops
    logic [TAG_LEN-1:0]   tag_mem  [WAYS][SETS];
    logic [LINE_SIZE-1:0] data_mem [WAYS][SETS];
    logic [WAYS-1:0]      valid_q  [SETS];
    logic [WAYS-1:0]      dirty_q  [SETS];
    logic [WAY_W-1:0]     rr_q     [SETS];

    cache_state_e         state_q, state_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic                 we_q, we_d;
    logic [DATA_LEN-1:0]  wdata_q, wdata_d;
    cache_line_t          victim_q, victim_d;
    logic [WAY_W-1:0]     vway_q, vway_d;
    logic [LINE_SIZE-1:0] fill_q, fill_d;
    logic [DATA_LEN-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                 fetch_sent_q, fetch_sent_d;

    // Array write controls produced by the next-state logic
    logic                 data_we, tag_we, meta_we, rr_we;
    logic [WAY_W-1:0]     data_way;
    logic [LINE_SIZE-1:0] data_line;
    logic [WAYS-1:0]      valid_set_d, dirty_set_d;
    logic [WAY_W-1:0]     rr_d;

    // Fields of the latched address
    logic [TAG_LEN-1:0]    w_tag;
    logic [INDEX_LEN-1:0]  w_idx;
    logic [OFFSET_LEN-1:0] w_off;
    assign w_tag = addr_q[ADDR_LEN-1 -: TAG_LEN];
    assign w_idx = addr_q[OFFSET_LEN +: INDEX_LEN];
    assign w_off = addr_q[OFFSET_LEN-1:0];

    logic [WAYS*TAG_LEN-1:0] w_set_tags;
    logic [WAYS-1:0]         w_hit_onehot;
    logic                    w_hit;
    logic [WAY_W-1:0]        w_hit_way, w_vsel;
    logic [LINE_SIZE-1:0]    w_hit_line;
    cache_line_t             w_victim;

    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_tags
            assign w_set_tags[g*TAG_LEN +: TAG_LEN] = tag_mem[g][w_idx];
        end
    endgenerate

    cache_way_sel #(
        .WAYS    (WAYS),
        .TAG_LEN (TAG_LEN),
        .WAY_W   (WAY_W)
    ) u_way_sel (
        .i_tag        (w_tag),
        .i_way_tags   (w_set_tags),
        .i_valid      (valid_q[w_idx]),
        .i_rr_ptr     (rr_q[w_idx]),
        .o_hit_onehot (w_hit_onehot),
        .o_hit        (w_hit),
        .o_hit_way    (w_hit_way),
        .o_victim_way (w_vsel)
    );

    assign w_hit_line      = data_mem[w_hit_way][w_idx];
    assign w_victim.valid  = valid_q[w_idx][w_vsel];
    assign w_victim.dirty  = dirty_q[w_idx][w_vsel];
    assign w_victim.tag    = TAG_MAX'(tag_mem[w_vsel][w_idx]);

    // Only the tag LSBs of the latched victim record drive the write-back
    logic w_unused_victim;
    assign w_unused_victim = ^{victim_q.valid, victim_q.dirty, victim_q.tag[TAG_MAX-1:TAG_LEN]};

    function automatic logic [LINE_SIZE-1:0] merge_word(input logic [LINE_SIZE-1:0] line,
                                                        input logic [OFFSET_LEN-1:0] off,
                                                        input logic [DATA_LEN-1:0]   word);
        logic [LINE_SIZE-1:0] l;
        l = line;
        l[off*DATA_LEN +: DATA_LEN] = word;
        return l;
    endfunction

    // Next-state, array write controls and response data
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        victim_d     = victim_q;
        vway_d       = vway_q;
        fill_d       = fill_q;
        rsp_rdata_d  = rsp_rdata_q;
        fetch_sent_d = fetch_sent_q;
        data_we      = 1'b0;
        tag_we       = 1'b0;
        meta_we      = 1'b0;
        rr_we        = 1'b0;
        data_way     = w_hit_way;
        data_line    = w_hit_line;
        valid_set_d  = valid_q[w_idx];
        dirty_set_d  = dirty_q[w_idx];
        rr_d         = (rr_q[w_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[w_idx] + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    if (we_q) begin
                        data_we     = 1'b1;
                        data_line   = merge_word(w_hit_line, w_off, wdata_q);
                        meta_we     = 1'b1;
                        dirty_set_d = dirty_q[w_idx] | w_hit_onehot;
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_rdata_d = w_hit_line[w_off*DATA_LEN +: DATA_LEN];
                    end
                    state_d = S_RESP;
                end else begin
                    victim_d     = w_victim;
                    vway_d       = w_vsel;
                    fetch_sent_d = 1'b0;
                    state_d      = (w_victim.valid && w_victim.dirty) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                if (mem_req_rdy) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (!fetch_sent_q) begin
                    if (mem_req_rdy) fetch_sent_d = 1'b1;
                end else if (mem_rsp_en) begin
                    fill_d       = mem_rsp_data;
                    fetch_sent_d = 1'b0;
                    state_d      = S_FILL;
                end
            end
            S_FILL: begin
                data_we              = 1'b1;
                data_way             = vway_q;
                data_line            = we_q ? merge_word(fill_q, w_off, wdata_q) : fill_q;
                tag_we               = 1'b1;
                meta_we              = 1'b1;
                valid_set_d[vway_q]  = 1'b1;
                dirty_set_d[vway_q]  = we_q;
                rr_we                = 1'b1;
                rsp_rdata_d          = we_q ? '0 : fill_q[w_off*DATA_LEN +: DATA_LEN];
                state_d              = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            victim_q     <= '0;
            vway_q       <= '0;
            fill_q       <= '0;
            rsp_rdata_q  <= '0;
            fetch_sent_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            victim_q     <= victim_d;
            vway_q       <= vway_d;
            fill_q       <= fill_d;
            rsp_rdata_q  <= rsp_rdata_d;
            fetch_sent_q <= fetch_sent_d;
        end
    end

    // Metadata flops: valid, dirty and round-robin pointers clear in one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            if (meta_we) begin
                valid_q[w_idx] <= valid_set_d;
                dirty_q[w_idx] <= dirty_set_d;
            end
            if (rr_we) rr_q[w_idx] <= rr_d;
        end
    end

    // Tag and data RAM writes
    always_ff @(posedge clk) begin
        if (data_we) data_mem[data_way][w_idx] <= data_line;
        if (tag_we)  tag_mem[vway_q][w_idx]    <= w_tag;
    end

    // Memory request outputs derive from state so they hold while stalled
    always_comb begin
        mem_req_en   = 1'b0;
        mem_req_cmd  = MEM_WR;
        mem_req_addr = '0;
        mem_req_data = '0;
        if (state_q == S_WB) begin
            mem_req_en   = 1'b1;
            mem_req_addr = {victim_q.tag[TAG_LEN-1:0], w_idx, {OFFSET_LEN{1'b0}}};
            mem_req_data = data_mem[vway_q][w_idx];
        end else if (state_q == S_FETCH && !fetch_sent_q) begin
            mem_req_en   = 1'b1;
            mem_req_cmd  = MEM_RD;
            mem_req_addr = {w_tag, w_idx, {OFFSET_LEN{1'b0}}};
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;
    logic [31:0] stat_wbs_q, stat_wbs_d;

    // Saturating event counters
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        stat_wbs_d    = stat_wbs_q;
        if (state_q == S_LOOKUP && w_hit && stat_hits_q != 32'hFFFF_FFFF)
            stat_hits_d = stat_hits_q + 32'd1;
        if (state_q == S_LOOKUP && !w_hit && stat_misses_q != 32'hFFFF_FFFF)
            stat_misses_d = stat_misses_q + 32'd1;
        if (state_q == S_WB && mem_req_rdy && stat_wbs_q != 32'hFFFF_FFFF)
            stat_wbs_d = stat_wbs_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_wbs_q    <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_wbs_q    <= stat_wbs_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_wbs    = stat_wbs_q;
`endif

    a_onehot_hit: assert property (@(posedge clk) disable iff (rst)
        (state_q == S_LOOKUP) |-> $onehot0(w_hit_onehot));
    a_rsp_in_fetch: assert property (@(posedge clk) disable iff (rst)
        mem_rsp_en |-> (state_q == S_FETCH));

endmodule
`default_nettype wire

// File: tb/tb_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_assoc
// Purpose  : Directed self-checking bench for cache_assoc (default params).
//            Memory line word i at line address LA is {4'hA, LA[25:0], i}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_assoc;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_we;
    logic [26:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         mem_req_en, mem_req_rdy, mem_req_cmd;
    logic [26:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_rsp_en;
    logic [127:0] mem_rsp_data;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_wbs;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_assoc dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_req_en   (mem_req_en),
        .mem_req_rdy  (mem_req_rdy),
        .mem_req_cmd  (mem_req_cmd),
        .mem_req_addr (mem_req_addr),
        .mem_req_data (mem_req_data),
        .mem_rsp_en   (mem_rsp_en),
        .mem_rsp_data (mem_rsp_data)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits    (stat_hits),
        .stat_misses  (stat_misses),
        .stat_wbs     (stat_wbs)
`endif
    );

    function automatic logic [127:0] mem_line(input logic [26:0] la);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = {4'hA, la[25:0], 2'(i)};
        return l;
    endfunction

    // One core transaction with an inline memory responder. lat counts the
    // cycle in which rsp_valid is seen, relative to the accept cycle.
    task automatic run_req(input logic we, input logic [26:0] addr, input logic [31:0] wd,
                           input int wb_stall, output logic [31:0] rd, output int lat,
                           output int nrd, output int nwr, output logic [26:0] rd_addr,
                           output logic [26:0] wb_addr, output logic [127:0] wb_data,
                           output bit stable);
        bit pend, done, seen;
        int stall_cnt;
        logic [26:0]  a0;
        logic [127:0] d0;
        rd = '0; nrd = 0; nwr = 0; rd_addr = '0; wb_addr = '0; wb_data = '0; stable = 1'b1;
        pend = 1'b0; done = 1'b0; seen = 1'b0; stall_cnt = 0; a0 = '0; d0 = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
        lat = 1;
        for (int c = 0; c < 300 && !done; c++) begin
            if (c > 0) begin
                @(negedge clk);
                lat++;
            end
            mem_rsp_en  = 1'b0;
            mem_req_rdy = 1'b0;
            if (rsp_valid) begin
                done = 1'b1;
                rd   = rsp_rdata;
            end else begin
                if (pend) begin
                    mem_rsp_en   = 1'b1;
                    mem_rsp_data = mem_line(rd_addr);
                    pend         = 1'b0;
                end
                if (mem_req_en) begin
                    if (mem_req_cmd == 1'b0) begin
                        if (!seen) begin
                            seen = 1'b1; a0 = mem_req_addr; d0 = mem_req_data;
                        end else if (mem_req_addr !== a0 || mem_req_data !== d0) begin
                            stable = 1'b0;
                        end
                        if (stall_cnt < wb_stall) begin
                            stall_cnt++;
                        end else begin
                            mem_req_rdy = 1'b1; nwr++;
                            wb_addr = mem_req_addr; wb_data = mem_req_data; seen = 1'b0;
                        end
                    end else begin
                        mem_req_rdy = 1'b1; nrd++; rd_addr = mem_req_addr; pend = 1'b1;
                    end
                end
            end
        end
        mem_rsp_en  = 1'b0;
        mem_req_rdy = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL timeout: no rsp_valid for addr %h", addr);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rsp_rdata); end
        checks++; if (mem_req_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_req_en); end
        checks++; if (mem_req_cmd !== 1'b0) begin errors++; $display("FAIL reset_mem_cmd got %b exp 0", mem_req_cmd); end
        checks++; if (mem_req_addr !== 27'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_req_addr); end
        checks++; if (mem_req_data !== 128'h0) begin errors++; $display("FAIL reset_mem_data got %h exp 0", mem_req_data); end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int lat, nrd, nwr; logic [26:0] ra, wa; logic [127:0] wdat; bit st;
        run_req(1'b0, 27'h10, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (rd !== 32'hA000_0040) begin errors++; $display("FAIL cold_rdata got %h exp A0000040", rd); end
        checks++; if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL cold_traffic got rd=%0d wr=%0d exp 1/0", nrd, nwr); end
        checks++; if (ra !== 27'h10) begin errors++; $display("FAIL cold_fetch_addr got %h exp 10", ra); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL cold_latency got %0d exp 5", lat); end
        run_req(1'b0, 27'h10, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (rd !== 32'hA000_0040) begin errors++; $display("FAIL hit_rdata got %h exp A0000040", rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL hit_latency got %0d exp 2", lat); end
        checks++; if (nrd !== 0 || nwr !== 0) begin errors++; $display("FAIL hit_traffic got rd=%0d wr=%0d exp 0/0", nrd, nwr); end
        run_req(1'b0, 27'h13, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (rd !== 32'hA000_0043) begin errors++; $display("FAIL hit_word3 got %h exp A0000043", rd); end
    endtask

    task automatic test_write_evict();
        logic [31:0] rd; int lat, nrd, nwr, tot_wr; logic [26:0] ra, wa; logic [127:0] wdat; bit st;
        run_req(1'b1, 27'h11, 32'hDEAD_BEEF, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (lat !== 2 || nrd !== 0) begin errors++; $display("FAIL wr_hit got lat=%0d rd=%0d exp 2/0", lat, nrd); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_hit_rdata got %h exp 0", rd); end
        run_req(1'b0, 27'h11, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_readback got %h exp DEADBEEF", rd); end
        tot_wr = 0;
        for (int t = 1; t <= 5; t++) begin
            run_req(1'b0, 27'((t << 10) | 'h10), 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
            tot_wr += nwr;
            if (t == 4) begin
                checks++; if (nwr !== 1) begin errors++; $display("FAIL evict_wb_count got %0d exp 1", nwr); end
                checks++; if (wa !== 27'h10) begin errors++; $display("FAIL evict_wb_addr got %h exp 10", wa); end
                checks++; if (wdat[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL evict_wb_word1 got %h exp DEADBEEF", wdat[63:32]); end
                checks++; if (wdat[31:0] !== 32'hA000_0040) begin errors++; $display("FAIL evict_wb_word0 got %h exp A0000040", wdat[31:0]); end
                checks++; if (lat !== 6) begin errors++; $display("FAIL dirty_latency got %0d exp 6", lat); end
            end
            if (t == 5) begin
                checks++; if (rd !== 32'hA000_5040) begin errors++; $display("FAIL conflict_rdata got %h exp A0005040", rd); end
            end
        end
        checks++; if (tot_wr !== 1) begin errors++; $display("FAIL total_wb got %0d exp 1", tot_wr); end
    endtask

    task automatic test_round_robin();
        logic [31:0] rd; int lat, nrd, nwr; logic [26:0] ra, wa; logic [127:0] wdat; bit st;
        // expected fetch count per access: tags 0..4 miss, then 0 miss, 2,3 hit, 1 miss, 4 hit
        int tags [10] = '{0, 1, 2, 3, 4, 0, 2, 3, 1, 4};
        int exp  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            run_req(1'b0, 27'(tags[i] << 10), 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
            checks++; if (nrd !== exp[i]) begin errors++; $display("FAIL rr_step%0d tag%0d fetches got %0d exp %0d", i, tags[i], nrd, exp[i]); end
        end
    endtask

    task automatic test_wb_stall();
        logic [31:0] rd; int lat, nrd, nwr; logic [26:0] ra, wa; logic [127:0] wdat; bit st;
        run_req(1'b1, 27'h20, 32'h0000_55AA, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (nrd !== 1 || lat !== 5 || rd !== 32'h0) begin errors++; $display("FAIL wr_miss got rd=%0d lat=%0d data=%h exp 1/5/0", nrd, lat, rd); end
        for (int t = 1; t <= 3; t++) run_req(1'b0, 27'((t << 10) | 'h20), 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        run_req(1'b0, 27'h1020, 32'h0, 10, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable got %b exp 1", st); end
        checks++; if (nwr !== 1 || wa !== 27'h20) begin errors++; $display("FAIL stall_wb got n=%0d addr=%h exp 1/20", nwr, wa); end
        checks++; if (wdat[63:0] !== 64'hA000_0081_0000_55AA) begin errors++; $display("FAIL stall_wb_data got %h exp A0000081000055AA", wdat[63:0]); end
        checks++; if (lat !== 16) begin errors++; $display("FAIL stall_latency got %0d exp 16", lat); end
        checks++; if (rd !== 32'hA000_4080) begin errors++; $display("FAIL stall_rdata got %h exp A0004080", rd); end
    endtask

    task automatic test_reset_fetch();
        logic [31:0] rd; int lat, nrd, nwr; logic [26:0] ra, wa; logic [127:0] wdat; bit st, found, early;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 27'h2030;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (mem_req_en && mem_req_cmd) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL rstfetch_reach got 0 exp 1"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || mem_req_en !== 1'b0) begin errors++; $display("FAIL rstfetch_state got ready=%b en=%b exp 1/0", req_ready, mem_req_en); end
        early = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) early = 1'b1;
            @(negedge clk);
        end
        checks++; if (early !== 1'b0) begin errors++; $display("FAIL rstfetch_no_rsp got %b exp 0", early); end
        run_req(1'b0, 27'h420, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (nrd !== 1 || rd !== 32'hA000_1080) begin errors++; $display("FAIL rstfetch_refetch got n=%0d data=%h exp 1/A0001080", nrd, rd); end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; int lat, nrd, nwr; logic [26:0] ra, wa; logic [127:0] wdat; bit st;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        run_req(1'b1, 27'h30, 32'h1234_5678, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        for (int i = 0; i < 3; i++) run_req(1'b0, 27'h30, 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        for (int t = 1; t <= 4; t++) run_req(1'b0, 27'((t << 10) | 'h30), 32'h0, 0, rd, lat, nrd, nwr, ra, wa, wdat, st);
        checks++; if (stat_hits !== 32'd3) begin errors++; $display("FAIL stat_hits got %0d exp 3", stat_hits); end
        checks++; if (stat_misses !== 32'd5) begin errors++; $display("FAIL stat_misses got %0d exp 5", stat_misses); end
        checks++; if (stat_wbs !== 32'd1) begin errors++; $display("FAIL stat_wbs got %0d exp 1", stat_wbs); end
    endtask
`endif

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_req_rdy = 1'b0; mem_rsp_en = 1'b0; mem_rsp_data = '0;
        test_reset();
        test_cold_read();
        test_write_evict();
        test_round_robin();
        test_wb_stall();
        test_reset_fetch();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
